// File: rtl/fifo_pack_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pack_pkg : shared types, defaults and keep-mask helper for the packer.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fifo_pack_pkg;

   localparam int DEF_WIDTH   = 8;
   localparam int DEF_LANES   = 4;
   localparam int DEF_TIMEOUT = 16;

   typedef enum logic [0:0] {
      FILL = 1'b0,
      OUT  = 1'b1
   } pack_state_t;

   // Low lane_cnt bits set; callers slice the LANES bits they need.
   function automatic logic [63:0] keep_mask(input logic [7:0] lane_cnt);
      return (64'd1 << lane_cnt) - 64'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/pack_idle_timer.sv
// ---------------------------------------------------------------------------
// pack_idle_timer : idle-cycle counter that pulses expire_o after TIMEOUT cycles.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pack_idle_timer #(
   parameter int TIMEOUT = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic count_en_i,
   output logic expire_o
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] count_q, count_d;

   always_comb begin
      count_d  = count_q;
      expire_o = 1'b0;
      if (clear_i) begin
         count_d = '0;
      end else if (count_en_i) begin
         if (count_q == CW'(TIMEOUT - 1)) begin
            expire_o = 1'b1;
            count_d  = '0;
         end else begin
            count_d = count_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) count_q <= '0;
      else       count_q <= count_d;
   end

endmodule

`default_nettype wire

// File: rtl/fifo_byte_packer.sv
// ---------------------------------------------------------------------------
// fifo_byte_packer : drains FIFO bytes into LANES-wide valid/ready words.
// Optional idle-timeout flush under PACK_TIMEOUT_EN.              Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fifo_byte_packer
   import fifo_pack_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int LANES   = DEF_LANES,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   fifo_empty_i,
   input  logic [WIDTH-1:0]       fifo_rdata_i,
   input  logic                   fifo_rd_error_i,
   output logic                   fifo_rd_en_o,
   input  logic                   flush_i,
   output logic                   m_valid_o,
   input  logic                   m_ready_i,
   output logic [WIDTH*LANES-1:0] m_data_o,
   output logic [LANES-1:0]       m_keep_o,
   output logic [7:0]             rd_err_cnt_o
);

   localparam int CNT_W = $clog2(LANES) + 1;

   pack_state_t            state_q, state_d;
   logic [CNT_W-1:0]       lane_cnt_q, lane_cnt_d;
   logic                   inflight_q;
   logic                   flush_pend_q, flush_pend_d;
   logic [WIDTH*LANES-1:0] data_q, data_d;
   logic [LANES-1:0]       keep_q, keep_d;
   logic [7:0]             err_cnt_q, err_cnt_d;

   logic                   w_capture;
   logic                   w_timeout_flush;
   logic [CNT_W-1:0]       w_fill_sum;
   logic [63:0]            w_mask;
   logic                   w_unused_mask;

   assign w_capture     = inflight_q && !fifo_rd_error_i;
   assign w_fill_sum    = lane_cnt_q + CNT_W'(inflight_q);
   assign w_mask        = keep_mask(8'(lane_cnt_q));
   assign w_unused_mask = ^w_mask[63:LANES];

   // Gated by rst_i so the read request drops the instant reset asserts.
   assign fifo_rd_en_o = !rst_i && (state_q == FILL) && !fifo_empty_i &&
                         !flush_pend_q && (w_fill_sum < CNT_W'(LANES));

`ifdef PACK_TIMEOUT_EN
   logic w_idle;
   assign w_idle = (state_q == FILL) && (lane_cnt_q != '0) && !inflight_q;

   pack_idle_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_idle_timer (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clear_i    (w_capture),
      .count_en_i (w_idle),
      .expire_o   (w_timeout_flush)
   );
`else
   localparam int UNUSED_TIMEOUT = TIMEOUT;
   assign w_timeout_flush = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      lane_cnt_d   = lane_cnt_q;
      data_d       = data_q;
      keep_d       = keep_q;
      flush_pend_d = flush_pend_q | flush_i | w_timeout_flush;
      err_cnt_d    = err_cnt_q;

      if (inflight_q && fifo_rd_error_i && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end

      case (state_q)
         FILL: begin
            if (w_capture) begin
               for (int i = 0; i < LANES; i++) begin
                  if (lane_cnt_q == CNT_W'(i)) data_d[i*WIDTH +: WIDTH] = fifo_rdata_i;
               end
               lane_cnt_d = lane_cnt_q + CNT_W'(1);
            end
            // A pending flush is consumed by whichever word leaves next.
            if (lane_cnt_d == CNT_W'(LANES)) begin
               state_d      = OUT;
               keep_d       = '1;
               flush_pend_d = flush_i;
            end else if (flush_pend_q && !inflight_q) begin
               if (lane_cnt_q != '0) begin
                  state_d = OUT;
                  keep_d  = w_mask[LANES-1:0];
               end
               flush_pend_d = flush_i;
            end
         end
         OUT: begin
            if (m_ready_i) begin
               state_d    = FILL;
               lane_cnt_d = '0;
               data_d     = '0;
               keep_d     = '0;
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= FILL;
         lane_cnt_q   <= '0;
         inflight_q   <= 1'b0;
         flush_pend_q <= 1'b0;
         data_q       <= '0;
         keep_q       <= '0;
         err_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         lane_cnt_q   <= lane_cnt_d;
         inflight_q   <= fifo_rd_en_o;
         flush_pend_q <= flush_pend_d;
         data_q       <= data_d;
         keep_q       <= keep_d;
         err_cnt_q    <= err_cnt_d;
      end
   end

   assign m_valid_o    = (state_q == OUT);
   assign m_data_o     = (state_q == OUT) ? data_q : '0;
   assign m_keep_o     = keep_q;
   assign rd_err_cnt_o = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_byte_packer.sv
// ---------------------------------------------------------------------------
// tb_fifo_byte_packer : scoreboard bench for fifo_byte_packer.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fifo_byte_packer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fifo_empty;
   logic [7:0]  fifo_rdata = '0;
   logic        fifo_rd_error = 1'b0;
   logic        fifo_rd_en;
   logic        flush = 1'b0;
   logic        m_valid;
   logic        m_ready = 1'b1;
   logic [31:0] m_data;
   logic [3:0]  m_keep;
   logic [7:0]  rd_err_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] mem     [0:63];
   logic       err_mem [0:63];
   logic [5:0] wr_ptr = '0;
   logic [5:0] rd_ptr = '0;
   logic [35:0] exp_q [$];

   always #5 clk = ~clk;

   fifo_byte_packer #(.WIDTH(8), .LANES(4), .TIMEOUT(16)) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .fifo_empty_i    (fifo_empty),
      .fifo_rdata_i    (fifo_rdata),
      .fifo_rd_error_i (fifo_rd_error),
      .fifo_rd_en_o    (fifo_rd_en),
      .flush_i         (flush),
      .m_valid_o       (m_valid),
      .m_ready_i       (m_ready),
      .m_data_o        (m_data),
      .m_keep_o        (m_keep),
      .rd_err_cnt_o    (rd_err_cnt)
   );

   // FIFO read side: registered data and error, valid the cycle after a read.
   assign fifo_empty = (wr_ptr == rd_ptr);
   always @(posedge clk) begin
      if (fifo_rd_en && (wr_ptr != rd_ptr)) begin
         fifo_rdata    <= mem[rd_ptr];
         fifo_rd_error <= err_mem[rd_ptr];
         rd_ptr        <= rd_ptr + 6'd1;
      end else begin
         fifo_rd_error <= 1'b0;
      end
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push_byte(input logic [7:0] b, input logic err);
      mem[wr_ptr]     = b;
      err_mem[wr_ptr] = err;
      wr_ptr          = wr_ptr + 6'd1;
   endtask

   task automatic expect_word(input logic [31:0] d, input logic [3:0] k);
      exp_q.push_back({k, d});
   endtask

   // Pop and compare each handshaken word against the scoreboard.
   task automatic collect(input string tag, input int n_words, input int budget);
      int got = 0;
      int cyc = 0;
      logic [35:0] e;
      while (got < n_words && cyc < budget) begin
         if (m_valid && m_ready) begin
            e = exp_q.pop_front();
            check_val({tag, "_data"}, 64'(m_data), 64'(e[31:0]));
            check_val({tag, "_keep"}, 64'(m_keep), 64'(e[35:32]));
            got++;
         end
         @(negedge clk);
         cyc++;
      end
      check_val({tag, "_words"}, 64'(got), 64'(n_words));
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
   endtask

   initial begin
      int first;
      int pulses;
      int vcount;
      logic [31:0] held;

      // Reset state
      repeat (2) @(negedge clk);
      check_val("rst_valid", 64'(m_valid), 64'd0);
      check_val("rst_keep",  64'(m_keep),  64'd0);
      check_val("rst_data",  64'(m_data),  64'd0);
      check_val("rst_rden",  64'(fifo_rd_en), 64'd0);
      check_val("rst_errcnt", 64'(rd_err_cnt), 64'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Full word: latency and read pulse count
      push_byte(8'h11, 1'b0); push_byte(8'h22, 1'b0);
      push_byte(8'h33, 1'b0); push_byte(8'h44, 1'b0);
      expect_word(32'h44332211, 4'b1111);
      #1;
      first  = -1;
      pulses = 0;
      for (int c = 0; c < 12; c++) begin
         if (c > 0) @(negedge clk);
         if (m_valid) begin
            first = c;
            break;
         end
         if (fifo_rd_en) pulses++;
      end
      check_val("full_latency", 64'(first), 64'd5);
      check_val("full_rd_pulses", 64'(pulses), 64'd4);
      collect("full", 1, 20);

      // Backpressure: first word held, no reads while presenting
      m_ready = 1'b0;
      for (int i = 1; i <= 8; i++) push_byte(8'((i << 4) | i), 1'b0);
      expect_word(32'h44332211, 4'b1111);
      expect_word(32'h88776655, 4'b1111);
      for (int c = 0; c < 20 && !m_valid; c++) @(negedge clk);
      check_val("bp_valid", 64'(m_valid), 64'd1);
      held = exp_q[0][31:0];
      vcount = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (!m_valid || m_data !== held || fifo_rd_en) vcount++;
      end
      check_val("bp_held_stable", 64'(vcount), 64'd0);
      m_ready = 1'b1;
      collect("bp", 2, 40);

      // Partial flush
      push_byte(8'hAA, 1'b0); push_byte(8'hBB, 1'b0);
      expect_word(32'h0000BBAA, 4'b0011);
      repeat (8) @(negedge clk);
      check_val("flush_pre_valid", 64'(m_valid), 64'd0);
      pulse_flush();
      collect("flush", 1, 20);

      // Flush with nothing held emits nothing
      repeat (2) @(negedge clk);
      pulse_flush();
      vcount = 0;
      for (int c = 0; c < 10; c++) begin
         if (m_valid) vcount++;
         @(negedge clk);
      end
      check_val("flush_empty_valid", 64'(vcount), 64'd0);

      // Read error drops the second byte
      push_byte(8'h01, 1'b0); push_byte(8'h02, 1'b1); push_byte(8'h03, 1'b0);
      push_byte(8'h04, 1'b0); push_byte(8'h05, 1'b0);
      expect_word(32'h05040301, 4'b1111);
      collect("rderr", 1, 30);
      check_val("rderr_cnt", 64'(rd_err_cnt), 64'd1);

      // Reset mid-word after two captured bytes
      push_byte(8'hE1, 1'b0); push_byte(8'hE2, 1'b0);
      repeat (6) @(negedge clk);
      push_byte(8'hC1, 1'b0); push_byte(8'hC2, 1'b0);
      push_byte(8'hC3, 1'b0); push_byte(8'hC4, 1'b0);
      expect_word(32'hC4C3C2C1, 4'b1111);
      #1;
      check_val("midrst_pre_rden", 64'(fifo_rd_en), 64'd1);
      rst = 1'b1;
      #1;
      check_val("midrst_valid", 64'(m_valid), 64'd0);
      check_val("midrst_keep",  64'(m_keep),  64'd0);
      check_val("midrst_data",  64'(m_data),  64'd0);
      check_val("midrst_rden",  64'(fifo_rd_en), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      collect("midrst", 1, 30);

      // Idle timeout on a lone byte
      push_byte(8'h5A, 1'b0);
      expect_word(32'h0000005A, 4'b0001);
`ifdef PACK_TIMEOUT_EN
      repeat (4) @(negedge clk);
      first = -1;
      for (int c = 0; c < 40; c++) begin
         if (m_valid) begin
            first = c;
            break;
         end
         @(negedge clk);
      end
      check_val("timeout_seen", 64'(first >= 12 && first <= 16), 64'd1);
      collect("timeout", 1, 5);
`else
      vcount = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (m_valid) vcount++;
      end
      check_val("no_timeout_valid", 64'(vcount), 64'd0);
      pulse_flush();
      collect("late_flush", 1, 20);
`endif

      check_val("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
